// File: rtl/pipelined_instruction_decoder_if.sv
// Handshake and decoded-field bundle between fetch, the decode stage and its consumer.
// The slave modport is the decoder's view; the master modport is the surrounding pipeline.
interface pipelined_instruction_decoder_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic              out_valid;
   logic              out_ready;
   logic [5:0]        out_opcode;
   logic [REG_AW-1:0] out_rs;
   logic [REG_AW-1:0] out_rt;
   logic [REG_AW-1:0] out_rd;
   logic [4:0]        out_shamt;
   logic [5:0]        out_funct;
   logic [DATA_W-1:0] out_imm_ext;
   logic [25:0]       out_jaddr;
   logic [1:0]        out_type;
   logic              out_illegal;

   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
             out_funct, out_imm_ext, out_jaddr, out_type, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_opcode, out_rs, out_rt, out_rd, out_shamt,
             out_funct, out_imm_ext, out_jaddr, out_type, out_illegal
   );
endinterface

// File: rtl/pipelined_instruction_decoder.sv
// Registered MIPS decode stage: field split, immediate extension, R/I/J classification,
// valid/ready on both sides with a one-word skid register, flush and a saturating accept counter.
module pipelined_instruction_decoder #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               flush,
   pipelined_instruction_decoder_if.slave     bus,
   output logic [CNT_W-1:0]                   instr_count
);

   typedef struct packed {
      logic [5:0]        opcode;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [4:0]        shamt;
      logic [5:0]        funct;
      logic [DATA_W-1:0] imm_ext;
      logic [25:0]       jaddr;
      logic [1:0]        typ;
      logic              illegal;
   } dec_t;

   typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

   state_t      state, state_nxt;
   logic        rdy;
   logic        acc, dlv;
   logic        ld_out, ld_skid, pop_skid;
   dec_t        dec, out_q, skid_q;
   logic [5:0]  op;
   logic [31:0] lui_w;

   // Decode straight off the input word; the result lands in out_q or skid_q.
   always_comb begin
      dec         = '0;
      op          = bus.in_instr[31:26];
      lui_w       = {bus.in_instr[15:0], 16'h0000};
      dec.opcode  = op;
      dec.illegal = (op == 6'h01) || (op[5:4] == 2'b01) || (op >= 6'h2C);
      if (op == 6'h00) begin
         dec.typ   = 2'd0;
         dec.rs    = REG_AW'(bus.in_instr[25:21]);
         dec.rt    = REG_AW'(bus.in_instr[20:16]);
         dec.rd    = REG_AW'(bus.in_instr[15:11]);
         dec.shamt = bus.in_instr[10:6];
         dec.funct = bus.in_instr[5:0];
      end else if (op == 6'h02 || op == 6'h03) begin
         dec.typ   = 2'd2;
         dec.jaddr = bus.in_instr[25:0];
      end else begin
         dec.typ = 2'd1;
         dec.rs  = REG_AW'(bus.in_instr[25:21]);
         dec.rt  = REG_AW'(bus.in_instr[20:16]);
         case (op)
            6'h0C, 6'h0D, 6'h0E: dec.imm_ext = DATA_W'(bus.in_instr[15:0]);
            6'h0F:               dec.imm_ext = DATA_W'($signed(lui_w));
            default:             dec.imm_ext = DATA_W'($signed(bus.in_instr[15:0]));
         endcase
      end
   end

   assign acc = bus.in_valid && rdy;
   assign dlv = (state != EMPTY) && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         rdy   <= 1'b0;
      end else begin
         state <= state_nxt;
         rdy   <= (state_nxt != SKID);
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY:   if (acc) state_nxt = FULL;
            FULL:    if (acc && !dlv) state_nxt = SKID;
                     else if (dlv && !acc) state_nxt = EMPTY;
            SKID:    if (dlv) state_nxt = FULL;
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // Flush suppresses every load; field registers may keep stale contents.
   always_comb begin
      ld_out   = 1'b0;
      ld_skid  = 1'b0;
      pop_skid = 1'b0;
      if (!flush) begin
         case (state)
            EMPTY:   ld_out = acc;
            FULL: begin
               ld_out  = acc && dlv;
               ld_skid = acc && !dlv;
            end
            SKID:    pop_skid = dlv;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (ld_out)        out_q <= dec;
         else if (pop_skid) out_q <= skid_q;
         if (ld_skid)       skid_q <= dec;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         instr_count <= '0;
      else if (acc && !flush && (instr_count != {CNT_W{1'b1}}))
         instr_count <= instr_count + CNT_W'(1);
   end

   assign bus.in_ready    = rdy;
   assign bus.out_valid   = (state != EMPTY);
   assign bus.out_opcode  = out_q.opcode;
   assign bus.out_rs      = out_q.rs;
   assign bus.out_rt      = out_q.rt;
   assign bus.out_rd      = out_q.rd;
   assign bus.out_shamt   = out_q.shamt;
   assign bus.out_funct   = out_q.funct;
   assign bus.out_imm_ext = out_q.imm_ext;
   assign bus.out_jaddr   = out_q.jaddr;
   assign bus.out_type    = out_q.typ;
   assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// Directed bench for the decode stage: field decode, immediate forms, skid/backpressure,
// flush, counter saturation (CNT_W=4) and asynchronous reset while holding two words.
module tb_pipelined_instruction_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic [3:0] instr_count;
   int         n_cmp = 0;
   int         n_err = 0;

   pipelined_instruction_decoder_if #(.DATA_W(32), .REG_AW(5)) bus ();

   pipelined_instruction_decoder #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .bus         (bus.slave),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      chk("rst_count", 64'(instr_count), 64'd0);
      rst_n = 1'b1;
      step();
      chk("rst_ready", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      rst_n        = 1'b0;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_instr = 32'h0;
      bus.out_ready = 1'b0;
      #3;
      chk("reset_in_ready",  64'(bus.in_ready),  64'd0);
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_count",     64'(instr_count),   64'd0);
      chk("reset_imm",       64'(bus.out_imm_ext), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("ready_after_rel", 64'(bus.in_ready), 64'd1);

      // add $3,$1,$2
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_instr  = 32'h0022_1820;
      step();
      chk("r_valid", 64'(bus.out_valid), 64'd1);
      chk("r_type",  64'(bus.out_type),  64'd0);
      chk("r_rs",    64'(bus.out_rs),    64'd1);
      chk("r_rt",    64'(bus.out_rt),    64'd2);
      chk("r_rd",    64'(bus.out_rd),    64'd3);
      chk("r_funct", 64'(bus.out_funct), 64'h20);
      chk("r_imm",   64'(bus.out_imm_ext), 64'd0);

      bus.in_instr = 32'h2008_FFFF;
      step();
      chk("addi_imm",  64'(bus.out_imm_ext), 64'hFFFF_FFFF);
      chk("addi_type", 64'(bus.out_type),    64'd1);
      chk("addi_rt",   64'(bus.out_rt),      64'd8);
      chk("addi_rd",   64'(bus.out_rd),      64'd0);
      chk("addi_funct",64'(bus.out_funct),   64'd0);
      bus.in_instr = 32'h3508_FFFF;
      step();
      chk("ori_imm",  64'(bus.out_imm_ext), 64'h0000_FFFF);
      chk("ori_type", 64'(bus.out_type),    64'd1);
      chk("ori_rs",   64'(bus.out_rs),      64'd8);
      bus.in_instr = 32'h3C08_1234;
      step();
      chk("lui_imm",  64'(bus.out_imm_ext), 64'h1234_0000);
      chk("lui_type", 64'(bus.out_type),    64'd1);
      chk("lui_ill",  64'(bus.out_illegal), 64'd0);

      bus.in_instr = 32'h0800_0010;
      step();
      chk("j_type",  64'(bus.out_type),  64'd2);
      chk("j_jaddr", 64'(bus.out_jaddr), 64'h10);
      chk("j_rs",    64'(bus.out_rs),    64'd0);
      chk("j_rt",    64'(bus.out_rt),    64'd0);
      chk("j_imm",   64'(bus.out_imm_ext), 64'd0);
      bus.in_instr = 32'h4000_0000;
      step();
      chk("ill_flag",  64'(bus.out_illegal), 64'd1);
      chk("ill_type",  64'(bus.out_type),    64'd1);
      chk("ill_jaddr", 64'(bus.out_jaddr),   64'd0);
      bus.in_valid = 1'b0;
      step();
      chk("drain_valid", 64'(bus.out_valid), 64'd0);
      chk("count6",      64'(instr_count),   64'd6);

      // backpressure into the skid register
      pulse_reset();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_instr  = 32'h0109_5020;
      step();
      chk("bp_valid1", 64'(bus.out_valid), 64'd1);
      chk("bp_ready1", 64'(bus.in_ready),  64'd1);
      chk("bp_rd1",    64'(bus.out_rd),    64'd10);
      bus.in_instr = 32'h2129_0005;
      step();
      chk("bp_ready2", 64'(bus.in_ready), 64'd0);
      chk("bp_frz_rd", 64'(bus.out_rd),   64'd10);
      bus.in_instr = 32'h000A_5880;
      step();
      chk("bp_ready3",  64'(bus.in_ready), 64'd0);
      chk("bp_frz_fn",  64'(bus.out_funct), 64'h20);
      chk("bp_count2",  64'(instr_count),  64'd2);
      bus.out_ready = 1'b1;
      step();
      chk("bp_w2_type", 64'(bus.out_type),    64'd1);
      chk("bp_w2_imm",  64'(bus.out_imm_ext), 64'd5);
      chk("bp_w2_rt",   64'(bus.out_rt),      64'd9);
      chk("bp_ready4",  64'(bus.in_ready),    64'd1);
      chk("bp_count2b", 64'(instr_count),     64'd2);
      step();
      chk("bp_w3_rd",    64'(bus.out_rd),    64'd11);
      chk("bp_w3_shamt", 64'(bus.out_shamt), 64'd2);
      chk("bp_count3",   64'(instr_count),   64'd3);
      bus.in_valid = 1'b0;
      step();
      chk("bp_drain", 64'(bus.out_valid), 64'd0);

      // flush while in SKID
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_instr  = 32'h0109_5020;
      step();
      bus.in_instr = 32'h2129_0005;
      step();
      chk("fl_skid_ready", 64'(bus.in_ready), 64'd0);
      flush        = 1'b1;
      bus.in_instr = 32'h000A_5880;
      step();
      flush = 1'b0;
      chk("fl_valid", 64'(bus.out_valid), 64'd0);
      chk("fl_ready", 64'(bus.in_ready),  64'd1);
      chk("fl_count", 64'(instr_count),   64'd5);

      // counter saturation
      bus.out_ready = 1'b1;
      bus.in_instr  = 32'h0109_5020;
      for (int i = 0; i < 9; i++) step();
      chk("sat_count14", 64'(instr_count), 64'd14);
      for (int i = 0; i < 5; i++) step();
      chk("sat_count15", 64'(instr_count), 64'd15);

      // async reset with two words held
      bus.out_ready = 1'b0;
      step();
      chk("ar_skid_ready", 64'(bus.in_ready),  64'd0);
      chk("ar_valid_pre",  64'(bus.out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 64'(bus.out_valid), 64'd0);
      chk("ar_rd",    64'(bus.out_rd),    64'd0);
      chk("ar_funct", 64'(bus.out_funct), 64'd0);
      chk("ar_ready", 64'(bus.in_ready),  64'd0);
      chk("ar_count", 64'(instr_count),   64'd0);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      step();
      chk("ar_post_valid", 64'(bus.out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
